// File: rtl/uart_msg_sender_if.sv
// uart_msg_sender_if: control/status and serial-pin bundle for the message sender
interface uart_msg_sender_if #(
    parameter int MAX_LEN = 32,
    parameter int ADDR_W  = $clog2(MAX_LEN)
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   len;
    logic              repeat_mode;
    logic              trigger;
    logic              abort;
    logic              tx;
    logic              busy;
    logic              char_strobe;
    logic [ADDR_W-1:0] char_idx;
    logic              done;
    modport master (
        output wr_en, wr_addr, wr_data, len, repeat_mode, trigger, abort,
        input  tx, busy, char_strobe, char_idx, done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, len, repeat_mode, trigger, abort,
        output tx, busy, char_strobe, char_idx, done
    );
endinterface

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: serialises the first len bytes of a writable buffer as 8N1 frames
module uart_msg_sender #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int MAX_LEN        = 32,
    parameter int ADDR_W         = $clog2(MAX_LEN)
) (
    input logic              clk,
    input logic              rst,
    uart_msg_sender_if.slave bus
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_buf [MAX_LEN];
    logic [7:0]        r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_len;
    logic              r_abort;
    logic              r_done;
    logic              w_last;
    logic              w_more;
    logic              w_tx;
    logic [ADDR_W:0]   w_len;

    // buffer write port, open in every state and never reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) r_buf[bus.wr_addr] <= bus.wr_data;
    end

    // next-state and serial output decode
    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        w_last = r_cnt == CNT_W'(CLOCKS_PER_BIT - 1);
        w_more = ((ADDR_W+1)'(r_idx) + (ADDR_W+1)'(1)) < r_len;
        w_len  = (bus.len > (ADDR_W+1)'(MAX_LEN)) ? (ADDR_W+1)'(MAX_LEN) : bus.len;
        case (r_state)
            IDLE:  w_next = (bus.trigger && w_len != '0) ? LOAD : IDLE;
            LOAD:  w_next = START;
            START: begin
                w_tx   = 1'b0;
                w_next = w_last ? DATA : START;
            end
            DATA: begin
                w_tx   = r_shift[r_bit];
                w_next = (w_last && r_bit == 3'd7) ? STOP : DATA;
            end
            STOP:  w_next = !w_last ? STOP : (r_abort || !(w_more || bus.repeat_mode)) ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    // state, bit timing, byte index and abort bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_abort <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_last) ? '0 : r_cnt + CNT_W'(1);
            r_bit   <= (r_state == DATA) ? r_bit + 3'(w_last) : 3'd0;
            r_abort <= (w_next == IDLE) ? 1'b0 : (r_state != IDLE) && (r_abort || bus.abort);
            r_done  <= (r_state != IDLE) && (w_next == IDLE);
            if (r_state == IDLE && w_next == LOAD) begin
                r_idx <= '0;
                r_len <= w_len;
            end else if (r_state == STOP && w_next == LOAD) begin
                r_idx <= w_more ? r_idx + ADDR_W'(1) : '0;
            end
        end
    end

    // byte fetch happens only in LOAD so late writes still reach the frame
    always_ff @(posedge clk) begin
        if (r_state == LOAD) r_shift <= r_buf[r_idx];
    end

    assign bus.tx          = w_tx;
    assign bus.busy        = r_state != IDLE;
    assign bus.char_strobe = r_state == LOAD;
    assign bus.char_idx    = r_idx;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_uart_msg_sender.sv
// tb_uart_msg_sender: scoreboard bench decoding tx frames and strobes against queued expectations
module tb_uart_msg_sender;
    localparam int C  = 4;
    localparam int ML = 16;
    localparam int FW = 10 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;
    int   n_busy = 0;
    int   n_strobe = 0;
    int   n_frames = 0;
    logic [7:0] mem [ML];
    logic [7:0] exp_q [$];
    int         idx_q [$];
    logic [FW-1:0] mon_w;
    logic [7:0]    mon_b;
    bit            mon_k;
    int b_done, b_busy, b_frames, b_strobe;

    uart_msg_sender_if #(.MAX_LEN(ML)) bus ();

    uart_msg_sender #(.CLOCKS_PER_BIT(C), .MAX_LEN(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] wave(input logic [7:0] b);
        logic [FW-1:0] w;
        for (int j = 0; j < FW; j++) w[j] = (j / C == 0) ? 1'b0 : (j / C == 9) ? 1'b1 : b[j / C - 1];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        mem[a]      = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic wait_strobe(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_strobe >= n) return;
        end
        chk("strobe_timeout", 0, 1);
    endtask

    task automatic mark();
        b_done   = n_done;
        b_busy   = n_busy;
        b_frames = n_frames;
        b_strobe = n_strobe;
    endtask

    // counts pulses, busy cycles and checks every fetched index
    always @(negedge clk) begin
        if (bus.done) n_done++;
        if (bus.busy) n_busy++;
        if (bus.char_strobe) begin
            n_strobe++;
            if (idx_q.size() == 0) chk("unexp_strobe", 1, 0);
            else chk("char_idx", 64'(bus.char_idx), 64'(idx_q.pop_front()));
        end
    end

    // captures each frame cycle by cycle; frames cut by rst are discarded
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.tx === 1'b0) begin
                mon_w    = '0;
                mon_k    = 1'b0;
                for (int j = 1; j < FW; j++) begin
                    @(negedge clk);
                    mon_w[j] = bus.tx;
                    if (rst) mon_k = 1'b1;
                end
                if (!mon_k) begin
                    n_frames++;
                    if (exp_q.size() == 0) chk("unexp_frame", 64'(mon_w), 0);
                    else begin
                        mon_b = exp_q.pop_front();
                        chk("frame", 64'(mon_w), 64'(wave(mon_b)));
                    end
                end
            end
        end
    end

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.len = 0;
        bus.repeat_mode = 0; bus.trigger = 0; bus.abort = 0;
        repeat (3) step();
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobe", bus.char_strobe, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_idx", bus.char_idx, 0);
        rst = 1'b0;
        step();

        wr(0, 8'h48); wr(1, 8'h69); wr(2, 8'h21);
        bus.len = 3;
        exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h21);
        idx_q.push_back(0); idx_q.push_back(1); idx_q.push_back(2);
        mark();
        pulse_trigger();
        chk("lat_busy", bus.busy, 1);
        chk("lat_strobe", bus.char_strobe, 1);
        step();
        chk("lat_tx", bus.tx, 0);
        wait_done();
        repeat (3) step();
        chk("hi_busy_cycles", n_busy - b_busy, 123);
        chk("hi_done", n_done - b_done, 1);
        chk("hi_strobes", n_strobe - b_strobe, 3);
        chk("hi_frames", n_frames - b_frames, 3);

        bus.len = 0;
        mark();
        bus.trigger = 1'b1;
        repeat (5) step();
        bus.trigger = 1'b0;
        chk("len0_tx", bus.tx, 1);
        repeat (5) step();
        chk("len0_busy", n_busy - b_busy, 0);
        chk("len0_done", n_done - b_done, 0);

        wr(0, 8'h41); wr(1, 8'h42);
        bus.len = 2;
        bus.repeat_mode = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h41); exp_q.push_back(8'h42);
            idx_q.push_back(0); idx_q.push_back(1);
        end
        mark();
        pulse_trigger();
        wait_strobe(b_strobe + 3);
        repeat (C * 4) step();
        bus.repeat_mode = 1'b0;
        wait_done();
        repeat (3) step();
        chk("rep_frames", n_frames - b_frames, 4);
        chk("rep_done", n_done - b_done, 1);

        wr(3, 8'hC3); wr(4, 8'h0F);
        bus.len = 5;
        exp_q.push_back(mem[0]); exp_q.push_back(mem[1]);
        idx_q.push_back(0); idx_q.push_back(1);
        mark();
        pulse_trigger();
        wait_strobe(b_strobe + 2);
        repeat (C * 3) @(posedge clk);
        #1 bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_done();
        repeat (C * 12) step();
        chk("abort_frames", n_frames - b_frames, 2);
        chk("abort_done", n_done - b_done, 1);
        chk("abort_idle", bus.busy, 0);

        bus.len = 3;
        exp_q.push_back(mem[0]);
        idx_q.push_back(0);
        mark();
        pulse_trigger();
        wait_strobe(b_strobe + 1);
        repeat (9 * C + 1) @(posedge clk);
        #1 bus.len = 1;
        exp_q.push_back(8'h55); exp_q.push_back(mem[2]);
        idx_q.push_back(1); idx_q.push_back(2);
        wr(1, 8'h55);
        wait_done();
        repeat (3) step();
        chk("late_frames", n_frames - b_frames, 3);
        chk("late_done", n_done - b_done, 1);

        bus.len = 2;
        idx_q.push_back(0);
        mark();
        pulse_trigger();
        step();
        step();
        chk("mid_start_tx", bus.tx, 0);
        rst = 1'b1;
        step();
        chk("rst_mid_tx", bus.tx, 1);
        chk("rst_mid_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (FW + 10) step();
        chk("rst_mid_done", n_done - b_done, 0);
        exp_q.push_back(mem[0]); exp_q.push_back(mem[1]);
        idx_q.push_back(0); idx_q.push_back(1);
        mark();
        pulse_trigger();
        wait_done();
        repeat (3) step();
        chk("restart_frames", n_frames - b_frames, 2);
        chk("restart_done", n_done - b_done, 1);

        chk("exp_left", exp_q.size(), 0);
        chk("idx_left", idx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_msg_sender.md
Name: uart_msg_sender

Overview:
Parametrised UART message transmitter. It holds a writable message buffer of up to MAX_LEN bytes and serialises the first len bytes as 8N1 frames on tx after a trigger. It supports one-shot and continuous repeat modes, plus a graceful abort. It sits between a control/status interface and the board UART pin, and replaces fixed-string senders.

Parameters:
CLOCKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2
MAX_LEN, 32, message buffer depth in bytes; must be >= 2
ADDR_W, $clog2(MAX_LEN), buffer index width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address
wr_data  in  8  buffer write data
len  in  ADDR_W+1  message length in bytes, 0..MAX_LEN
repeat_mode  in  1  1 = resend message continuously
trigger  in  1  start request, level- or pulse-driven
abort  in  1  stop after the current frame
tx  out  1  UART serial output, idles high
busy  out  1  high from the accepted trigger until return to IDLE
char_strobe  out  1  1-cycle pulse when a byte is fetched
char_idx  out  ADDR_W  index of the byte currently being sent
done  out  1  1-cycle pulse on return to IDLE

Behaviour:
- Reset values: tx=1, busy=0, char_strobe=0, done=0, char_idx=0, state=IDLE. Buffer contents are not reset.
- Buffer: synchronous write on wr_en, in any state. The byte at index i is read only in the LOAD cycle for i, so a write lands in the frame if it occurs before that cycle.
- len is latched into len_q when a trigger is accepted. Later changes to len do not affect the current run. len values above MAX_LEN are clamped to MAX_LEN.
- Trigger acceptance: in IDLE with trigger=1 and len!=0. Otherwise trigger is ignored, including while busy.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: accepted trigger -> LOAD, idx=0, busy=1 from the next cycle.
- LOAD (1 cycle): shift register <= buf[idx]; char_strobe=1; char_idx=idx; tx=1 -> START.
- START: tx=0 for CLOCKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each held CLOCKS_PER_BIT cycles; bit counter 0..7 -> STOP.
- STOP: tx=1 for CLOCKS_PER_BIT cycles. At the last STOP cycle:
  - abort_pending -> IDLE.
  - else if idx < len_q-1 -> idx+1, LOAD.
  - else if repeat_mode=1 (sampled at this cycle) -> idx=0, LOAD.
  - else -> IDLE.
- Frame timing: 10*CLOCKS_PER_BIT + 1 cycles per byte. Total one-shot busy time is len_q*(10*CLOCKS_PER_BIT+1) cycles.
- Latency: trigger sampled at cycle t -> busy=1 and LOAD at t+1 -> tx falls at t+2.
- Exit to IDLE: busy=0 and done=1 in the same cycle (the first IDLE cycle). done lasts 1 cycle. A trigger held high during that cycle is accepted (back-to-back runs allowed).
- abort: while busy, sets abort_pending, which is cleared on entering IDLE. A frame in progress always completes its stop bit; no truncated frames. abort in IDLE is ignored. abort in the same cycle as an accepted trigger is ignored.
- Bit-period counter: counts 0..CLOCKS_PER_BIT-1. Width is $clog2(CLOCKS_PER_BIT). It resets on every state change.
- rst mid-frame: tx returns to 1 the next cycle, busy=0, no done pulse.

Test Plan:
- CLOCKS_PER_BIT=4, MAX_LEN=16. Write buf[0..2]="Hi!", len=3, trigger pulse -> bytes 0x48, 0x69, 0x21 on tx. Frame for 0x48 is 0,0,0,0,1,0,0,1,0,1, each bit 4 cycles. busy high for 123 cycles. Exactly one done pulse. char_strobe 3 times with char_idx 0, 1, 2.
- len=0, trigger -> busy stays 0, tx stays 1, no done.
- repeat_mode=1, len=2 ("AB") -> A, B, A, B, ... Clear repeat_mode during the second "A" -> finishes "B", then done. Total 4 frames.
- abort asserted mid DATA of byte 1 of 5 -> byte 1 completes with stop bit, then IDLE and done. Only 2 frames sent.
- Write buf[1]=0x55 while byte 0 is in STOP -> byte 1 sent as 0x55. len changed mid-run -> no effect on the number of bytes.
- rst asserted mid-START -> tx=1, busy=0 next cycle. A subsequent trigger restarts from idx 0 with correct framing.
